// File: rtl/rv32im_dmem_initiator.sv
// rtl/rv32im_dmem_initiator.sv - RV32IM load/store initiator for the dmem request/response bus

module rv32im_dmem_initiator #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic              op_store_i,
    input  logic [2:0]        op_funct3_i,
    input  logic [ADDR_W-1:0] op_addr_i,
    input  logic [ADDR_W-1:0] op_wdata_i,
    output logic              res_valid_o,
    output logic [ADDR_W-1:0] res_data_o,
    output logic              res_misaligned_o,
    output logic              res_timeout_o,
    output logic [ADDR_W-1:0] dmem_req_addr_o,
    output logic [ADDR_W-1:0] dmem_req_data_o,
    output logic              dmem_req_valid_o,
    output logic [3:0]        dmem_req_write_en_o,
    input  logic              dmem_accept_i,
    input  logic              dmem_resp_valid_i,
    input  logic [ADDR_W-1:0] dmem_resp_data_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Terminal count of the REQ+WAIT budget; the counter saturates so it never wraps back below it.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;

    // Latched op fields needed after the IDLE handshake.
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        lane_q, lane_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        cnt_inc;

    // Registered outputs.
    logic              op_ready_q, op_ready_d;
    logic              res_valid_q, res_valid_d;
    logic [ADDR_W-1:0] res_data_q, res_data_d;
    logic              res_mis_q, res_mis_d;
    logic              res_to_q, res_to_d;
    logic              req_valid_q, req_valid_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] req_data_q, req_data_d;
    logic [3:0]        req_we_q, req_we_d;

    // Decode of the incoming op.
    logic              op_legal;
    logic              op_unaligned;
    logic              op_bad;
    logic [3:0]        st_we;
    logic [ADDR_W-1:0] st_data;

    // Response lane extraction.
    logic [7:0]        resp_byte;
    logic [15:0]       resp_half;
    logic [ADDR_W-1:0] load_ext;

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // Classify the presented op: illegal funct3 for the direction, or address not aligned to the size.
    always_comb begin
        op_legal     = 1'b0;
        op_unaligned = 1'b0;
        case (op_funct3_i)
            F3_B, F3_H, F3_W: op_legal = 1'b1;
            F3_BU, F3_HU:     op_legal = !op_store_i;
            default:          op_legal = 1'b0;
        endcase
        case (op_funct3_i[1:0])
            2'b01:   op_unaligned = op_addr_i[0];
            2'b10:   op_unaligned = |op_addr_i[1:0];
            default: op_unaligned = 1'b0;
        endcase
        op_bad = !op_legal || op_unaligned;
    end

    // Byte-lane enables and lane-replicated store data; replication lets the responder pick any lane.
    always_comb begin
        st_we   = 4'b1111;
        st_data = op_wdata_i;
        case (op_funct3_i[1:0])
            2'b00: begin
                st_we   = 4'b0001 << op_addr_i[1:0];
                st_data = {(ADDR_W/8){op_wdata_i[7:0]}};
            end
            2'b01: begin
                st_we   = 4'b0011 << op_addr_i[1:0];
                st_data = {(ADDR_W/16){op_wdata_i[15:0]}};
            end
            default: begin
                st_we   = 4'b1111;
                st_data = op_wdata_i;
            end
        endcase
    end

    // Pick the addressed byte/halfword from the response word and extend it.
    always_comb begin
        resp_byte = dmem_resp_data_i[{lane_q, 3'b000} +: 8];
        resp_half = dmem_resp_data_i[{lane_q[1], 4'b0000} +: 16];
        load_ext  = dmem_resp_data_i;
        case (funct3_q)
            F3_B:    load_ext = {{(ADDR_W-8){resp_byte[7]}}, resp_byte};
            F3_BU:   load_ext = {{(ADDR_W-8){1'b0}}, resp_byte};
            F3_H:    load_ext = {{(ADDR_W-16){resp_half[15]}}, resp_half};
            F3_HU:   load_ext = {{(ADDR_W-16){1'b0}}, resp_half};
            default: load_ext = dmem_resp_data_i;
        endcase
    end

    // Next-state and next-output logic; every output is recomputed each cycle and registered.
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        res_valid_d = 1'b0;
        res_data_d  = '0;
        res_mis_d   = 1'b0;
        res_to_d    = 1'b0;
        req_valid_d = 1'b0;
        req_addr_d  = '0;
        req_data_d  = '0;
        req_we_d    = 4'b0000;

        unique case (state_q)
            S_IDLE: begin
                if (op_valid_i && op_ready_q) begin
                    store_d  = op_store_i;
                    funct3_d = op_funct3_i;
                    lane_d   = op_addr_i[1:0];
                    if (op_bad) begin
                        // Rejected ops never touch the bus.
                        state_d     = S_DONE;
                        res_valid_d = 1'b1;
                        res_mis_d   = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = 8'd0;
                        req_valid_d = 1'b1;
                        req_addr_d  = {op_addr_i[ADDR_W-1:2], 2'b00};
                        req_we_d    = op_store_i ? st_we : 4'b0000;
                        req_data_d  = op_store_i ? st_data : '0;
                    end
                end
            end

            S_REQ: begin
                if (dmem_accept_i) begin
                    // Accept beats a timeout landing on the same cycle.
                    cnt_d = cnt_inc;
                    if (store_q) begin
                        state_d     = S_DONE;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    res_valid_d = 1'b1;
                    res_to_d    = 1'b1;
                end else begin
                    cnt_d       = cnt_inc;
                    req_valid_d = 1'b1;
                    req_addr_d  = req_addr_q;
                    req_data_d  = req_data_q;
                    req_we_d    = req_we_q;
                end
            end

            S_WAIT: begin
                if (dmem_resp_valid_i) begin
                    state_d     = S_DONE;
                    res_valid_d = 1'b1;
                    res_data_d  = load_ext;
                end else if (cnt_q >= CNT_LAST) begin
                    // An accept on the terminal count leaves the load one cycle to see its data.
                    state_d     = S_DONE;
                    res_valid_d = 1'b1;
                    res_to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        op_ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset drops any in-flight op without a completion pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            store_q     <= 1'b0;
            funct3_q    <= 3'b000;
            lane_q      <= 2'b00;
            cnt_q       <= 8'd0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_mis_q   <= 1'b0;
            res_to_q    <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_we_q    <= 4'b0000;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_mis_q   <= res_mis_d;
            res_to_q    <= res_to_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_we_q    <= req_we_d;
        end
    end

    assign op_ready_o          = op_ready_q;
    assign res_valid_o         = res_valid_q;
    assign res_data_o          = res_data_q;
    assign res_misaligned_o    = res_mis_q;
    assign res_timeout_o       = res_to_q;
    assign dmem_req_valid_o    = req_valid_q;
    assign dmem_req_addr_o     = req_addr_q;
    assign dmem_req_data_o     = req_data_q;
    assign dmem_req_write_en_o = req_we_q;

endmodule

// File: tb/tb_rv32im_dmem_initiator.sv
// tb/tb_rv32im_dmem_initiator.sv - self-checking bench for rv32im_dmem_initiator

module tb_rv32im_dmem_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic        op_store;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_misaligned;
    logic        res_timeout;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_data;
    logic        dmem_req_valid;
    logic [3:0]  dmem_req_write_en;
    logic        dmem_accept;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv32im_dmem_initiator #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .op_valid_i          (op_valid),
        .op_ready_o          (op_ready),
        .op_store_i          (op_store),
        .op_funct3_i         (op_funct3),
        .op_addr_i           (op_addr),
        .op_wdata_i          (op_wdata),
        .res_valid_o         (res_valid),
        .res_data_o          (res_data),
        .res_misaligned_o    (res_misaligned),
        .res_timeout_o       (res_timeout),
        .dmem_req_addr_o     (dmem_req_addr),
        .dmem_req_data_o     (dmem_req_data),
        .dmem_req_valid_o    (dmem_req_valid),
        .dmem_req_write_en_o (dmem_req_write_en),
        .dmem_accept_i       (dmem_accept),
        .dmem_resp_valid_i   (dmem_resp_valid),
        .dmem_resp_data_i    (dmem_resp_data)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          acc;
        int          resp;
        logic [31:0] word;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [3:0]  exp_we;
        logic [31:0] exp_wd;
        logic [31:0] exp_data;
        logic        exp_mis;
        logic        exp_to;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int acc, input int resp,
                                input logic [31:0] word, input logic exp_req,
                                input logic [31:0] exp_addr, input logic [3:0] exp_we,
                                input logic [31:0] exp_wd, input logic [31:0] exp_data,
                                input logic exp_mis, input logic exp_to, input int exp_lat);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.acc = acc; v.resp = resp; v.word = word;
        v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_we = exp_we;
        v.exp_wd = exp_wd; v.exp_data = exp_data;
        v.exp_mis = exp_mis; v.exp_to = exp_to; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Reference: results derived from access size, byte offset and responder delays.
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] word,
                         input int acc, input int resp, output vec_t v);
        int     sz;
        int     off;
        int     nb;
        bit     legal;
        longint val;
        v = mk(st, f3, addr, wdata, acc, resp, word, 0, 0, 0, 0, 0, 0, 0, 1);
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        sz  = 1 << f3[1:0];
        off = int'(addr % 32'd4);
        v.exp_mis = !legal || ((off % sz) != 0);
        if (!v.exp_mis) begin
            v.exp_req  = 1;
            v.exp_addr = addr - 32'(off);
            if (st) begin
                v.exp_we = 4'(((1 << sz) - 1) << off);
                for (int i = 0; i < 4; i++) v.exp_wd[8*i +: 8] = wdata[8*(i % sz) +: 8];
                v.exp_lat = 2 + acc;
            end else begin
                nb  = 8 * sz;
                val = longint'(word >> (8 * off)) & ((longint'(1) << nb) - 1);
                if (f3[2] == 1'b0 && sz < 4 && val >= (longint'(1) << (nb - 1)))
                    val = val - (longint'(1) << nb);
                v.exp_data = val[31:0];
                v.exp_lat  = 3 + acc + resp;
            end
        end
    endtask

    // Issue one op, play the responder, observe the bus and the result, then compare.
    task automatic check_op(input string nm, input vec_t v, input bit junk);
        bit          req_seen = 0;
        bit          stable = 1;
        bit          accepted = 0;
        bit          one_shot;
        logic [31:0] r_addr = '0;
        logic [31:0] r_wd = '0;
        logic [3:0]  r_we = '0;
        logic [31:0] rd = '0;
        logic        rm = 0;
        logic        rt = 0;
        int          lat = 0;
        int          req_n = 0;
        int          wait_n = 0;
        int          w = 0;
        int          exp_reqn;

        while (op_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        op_valid = 1; op_store = v.st; op_funct3 = v.f3; op_addr = v.addr; op_wdata = v.wdata;
        @(negedge clk);
        op_valid = 0; op_store = 1'($urandom); op_funct3 = 3'($urandom);
        op_addr = $urandom; op_wdata = $urandom;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            dmem_accept = 0; dmem_resp_valid = 0; dmem_resp_data = $urandom;
            if (res_valid === 1'b1) begin
                lat = cyc; rd = res_data; rm = res_misaligned; rt = res_timeout;
                break;
            end
            if (dmem_req_valid === 1'b1) begin
                if (!req_seen) begin
                    req_seen = 1; r_addr = dmem_req_addr; r_wd = dmem_req_data; r_we = dmem_req_write_en;
                end else if (dmem_req_addr !== r_addr || dmem_req_data !== r_wd || dmem_req_write_en !== r_we) begin
                    stable = 0;
                end
                if (req_n == v.acc) begin
                    dmem_accept = 1; accepted = 1;
                end
                if (junk) dmem_resp_valid = 1;
                req_n++;
            end else if (accepted && !v.st) begin
                if (wait_n == v.resp) begin
                    dmem_resp_valid = 1; dmem_resp_data = v.word;
                end
                wait_n++;
            end
            @(negedge clk);
        end
        dmem_accept = 0; dmem_resp_valid = 0;
        @(negedge clk);
        one_shot = (res_valid === 1'b0 && res_data === 32'h0 && res_misaligned === 1'b0 &&
                    res_timeout === 1'b0 && op_ready === 1'b1);

        exp_reqn = !v.exp_req ? 0 : ((v.acc >= 16) ? 16 : v.acc + 1);
        chk({nm, " req_seen"}, 32'(req_seen), 32'(v.exp_req));
        chk({nm, " req_cycles"}, 32'(req_n), 32'(exp_reqn));
        if (v.exp_req) begin
            chk({nm, " req_addr"}, r_addr, v.exp_addr);
            chk({nm, " write_en"}, 32'(r_we), 32'(v.exp_we));
            chk({nm, " req_stable"}, 32'(stable), 32'd1);
            if (v.st) chk({nm, " req_data"}, r_wd, v.exp_wd);
        end
        if (v.exp_mis) chk({nm, " latency_1to2"}, 32'(lat >= 1 && lat <= 2), 32'd1);
        else           chk({nm, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({nm, " res_data"}, rd, v.exp_data);
        chk({nm, " res_misaligned"}, 32'(rm), 32'(v.exp_mis));
        chk({nm, " res_timeout"}, 32'(rt), 32'(v.exp_to));
        chk({nm, " one_cycle_pulse"}, 32'(one_shot), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        bit   no_res;

        rst = 1; op_valid = 0; op_store = 0; op_funct3 = 0; op_addr = 0; op_wdata = 0;
        dmem_accept = 0; dmem_resp_valid = 0; dmem_resp_data = 0;

        //          st f3  addr          wdata         acc resp word           req addr          we     wd            data          mis to lat
        vecs.push_back(mk(1, 2, 32'h0000_1004, 32'hDEAD_BEEF, 0,  0, 32'h0,          1, 32'h0000_1004, 4'hF, 32'hDEAD_BEEF, 32'h0,          0, 0, 2));
        vecs.push_back(mk(1, 0, 32'h0000_2003, 32'h0000_00A5, 0,  0, 32'h0,          1, 32'h0000_2000, 4'h8, 32'hA5A5_A5A5, 32'h0,          0, 0, 2));
        vecs.push_back(mk(0, 0, 32'h0000_2003, 32'h0,         0,  0, 32'hA500_0000,  1, 32'h0000_2000, 4'h0, 32'h0,         32'hFFFF_FFA5,  0, 0, 3));
        vecs.push_back(mk(0, 4, 32'h0000_2003, 32'h0,         0,  0, 32'hA500_0000,  1, 32'h0000_2000, 4'h0, 32'h0,         32'h0000_00A5,  0, 0, 3));
        vecs.push_back(mk(0, 1, 32'h0000_3002, 32'h0,         0,  0, 32'h8001_7FFF,  1, 32'h0000_3000, 4'h0, 32'h0,         32'hFFFF_8001,  0, 0, 3));
        vecs.push_back(mk(0, 5, 32'h0000_3002, 32'h0,         0,  0, 32'h8001_7FFF,  1, 32'h0000_3000, 4'h0, 32'h0,         32'h0000_8001,  0, 0, 3));
        vecs.push_back(mk(0, 1, 32'h0000_3000, 32'h0,         0,  0, 32'h8001_7FFF,  1, 32'h0000_3000, 4'h0, 32'h0,         32'h0000_7FFF,  0, 0, 3));
        vecs.push_back(mk(0, 2, 32'h0000_4002, 32'h0,         0,  0, 32'h0,          0, 32'h0,         4'h0, 32'h0,         32'h0,          1, 0, 1));
        vecs.push_back(mk(1, 1, 32'h0000_4001, 32'h1234_5678, 0,  0, 32'h0,          0, 32'h0,         4'h0, 32'h0,         32'h0,          1, 0, 1));
        vecs.push_back(mk(1, 1, 32'h0000_4002, 32'h1234_BEEF, 2,  0, 32'h0,          1, 32'h0000_4000, 4'hC, 32'hBEEF_BEEF, 32'h0,          0, 0, 4));
        vecs.push_back(mk(0, 3, 32'h0000_0010, 32'h0,         0,  0, 32'h0,          0, 32'h0,         4'h0, 32'h0,         32'h0,          1, 0, 1));
        vecs.push_back(mk(1, 4, 32'h0000_0020, 32'h0,         0,  0, 32'h0,          0, 32'h0,         4'h0, 32'h0,         32'h0,          1, 0, 1));
        vecs.push_back(mk(1, 2, 32'h0000_5000, 32'h1122_3344, 255, 0, 32'h0,         1, 32'h0000_5000, 4'hF, 32'h1122_3344, 32'h0,          0, 1, 17));
        vecs.push_back(mk(1, 2, 32'h0000_5004, 32'h5566_7788, 15, 0, 32'h0,          1, 32'h0000_5004, 4'hF, 32'h5566_7788, 32'h0,          0, 0, 17));
        vecs.push_back(mk(0, 2, 32'h0000_6000, 32'h0,         15, 0, 32'hCAFE_F00D,  1, 32'h0000_6000, 4'h0, 32'h0,         32'hCAFE_F00D,  0, 0, 18));
        vecs.push_back(mk(0, 2, 32'h0000_6004, 32'h0,         3, 11, 32'h0BAD_C0DE,  1, 32'h0000_6004, 4'h0, 32'h0,         32'h0BAD_C0DE,  0, 0, 17));
        vecs.push_back(mk(0, 2, 32'h0000_6008, 32'h0,         3, 12, 32'h0BAD_C0DE,  1, 32'h0000_6008, 4'h0, 32'h0,         32'h0,          0, 1, 17));
        vecs.push_back(mk(0, 0, 32'h0000_7001, 32'h0,         1,  2, 32'h0000_8000,  1, 32'h0000_7000, 4'h0, 32'h0,         32'hFFFF_FF80,  0, 0, 6));
        vecs.push_back(mk(0, 5, 32'h0000_7002, 32'h0,         0,  1, 32'hFFFF_0000,  1, 32'h0000_7000, 4'h0, 32'h0,         32'h0000_FFFF,  0, 0, 4));

        repeat (3) @(negedge clk);
        chk("reset op_ready", 32'(op_ready), 32'd0);
        chk("reset flags", 32'({res_valid, res_misaligned, res_timeout, dmem_req_valid, dmem_req_write_en}), 32'd0);
        chk("reset res_data", res_data, 32'h0);
        chk("reset req_addr", dmem_req_addr, 32'h0);
        rst = 0;
        @(negedge clk);
        chk("op_ready after reset", 32'(op_ready), 32'd1);

        foreach (vecs[i]) check_op($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Load dropped by a one-cycle reset while waiting for its data.
        op_valid = 1; op_store = 0; op_funct3 = 3'd2; op_addr = 32'h20; op_wdata = 0;
        @(negedge clk);
        op_valid = 0; dmem_accept = 1;
        @(negedge clk);
        dmem_accept = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midreset op_ready", 32'(op_ready), 32'd0);
        chk("midreset flags", 32'({res_valid, res_misaligned, res_timeout, dmem_req_valid, dmem_req_write_en}), 32'd0);
        chk("midreset res_data", res_data, 32'h0);
        chk("midreset req_addr", dmem_req_addr, 32'h0);
        dmem_resp_valid = 1; dmem_resp_data = 32'hFFFF_FFFF;
        no_res = 1;
        @(negedge clk);
        chk("midreset op_ready after", 32'(op_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (res_valid !== 1'b0) no_res = 0;
            @(negedge clk);
        end
        dmem_resp_valid = 0;
        chk("midreset no res_valid", 32'(no_res), 32'd1);
        check_op("after_reset_lw", mk(0, 2, 32'h10, 32'h0, 0, 0, 32'h1234_5678,
                                      1, 32'h10, 4'h0, 32'h0, 32'h1234_5678, 0, 0, 3), 1'b0);

        for (int n = 0; n < 40; n++) begin
            model(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), v);
            check_op($sformatf("rnd%0d", n), v, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
